// File: rtl/vector_mem_pkg.sv
// Shared types and helpers for the vector memory bridge.
// States, SEW codes, bus widths and the element mask function.
package vector_mem_pkg;

  localparam int BUS_DW  = 32;
  localparam int LINE_DW = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } state_t;

  localparam logic [1:0] SEW8  = 2'b00;
  localparam logic [1:0] SEW16 = 2'b01;
  localparam logic [1:0] SEW32 = 2'b10;

  function automatic logic [3:0] sew_mask(
    input logic [1:0] sew
  );
    logic [3:0] m;
    unique case (sew)
      SEW8:    m = 4'h1;
      SEW16:   m = 4'h3;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vmem_elem_align.sv
// Byte-lane alignment for single-element accesses.
// Shifts write data and enables into place, extracts the read lane.
module vmem_elem_align
  import vector_mem_pkg::*;
(
  input  logic [1:0]        sew,
  input  logic [1:0]        off,
  input  logic [BUS_DW-1:0] wdata,
  input  logic [BUS_DW-1:0] rdata,
  output logic [3:0]        be,
  output logic [BUS_DW-1:0] wdata_sh,
  output logic [BUS_DW-1:0] rlane
);

  logic [3:0]        mask;
  logic [4:0]        sh;
  logic [BUS_DW-1:0] bmask;

  assign mask = sew_mask(sew);
  assign sh   = {off, 3'b000};

  // Bytes pushed past bit 31 fall off the top of the word.
  assign be       = mask << off;
  assign wdata_sh = wdata << sh;

  assign bmask = {{8{mask[3]}}, {8{mask[2]}},
                  {8{mask[1]}}, {8{mask[0]}}};
  assign rlane = (rdata >> sh) & bmask;

endmodule

// File: rtl/vector_mem_bridge.sv
// Splits 256-bit vector line requests into 32-bit word beats.
// One request in flight; reads reassemble and pulse mem_valid_o.
module vector_mem_bridge
  import vector_mem_pkg::*;
#(
  parameter int BEATS = 8,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid_rd,
  input  logic                    mem_valid_wr,
  input  logic                    mem_unit,
  input  logic [1:0]              mem_sew,
  input  logic [AW-1:0]           mem_address,
  input  logic [BUS_DW*BEATS-1:0] mem_data_wr,
  output logic                    mem_ready,
  output logic                    mem_valid_o,
  output logic [BUS_DW*BEATS-1:0] mem_data_o,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [AW-1:0]           bus_addr,
  output logic [BUS_DW-1:0]       bus_wdata,
  output logic [3:0]              bus_be,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [BUS_DW-1:0]       bus_rdata
);

  localparam int LDW = BUS_DW * BEATS;
  localparam int CW  = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     icnt, rcnt;
  logic              r_we, r_unit;
  logic [1:0]        r_sew, r_off;
  logic [AW-1:0]     r_base;
  logic [LDW-1:0]    r_wdata, rbuf, nbuf;
  logic [3:0]        al_be;
  logic [BUS_DW-1:0] al_wdata, al_rlane;
  logic              accept, issue;
  logic              gnt_hit, rd_hit, last_i, last_r;

  vmem_elem_align u_align (
    .sew      (r_sew),
    .off      (r_off),
    .wdata    (r_wdata[BUS_DW-1:0]),
    .rdata    (bus_rdata),
    .be       (al_be),
    .wdata_sh (al_wdata),
    .rlane    (al_rlane)
  );

  assign issue   = (state == ISSUE);
  assign accept  = (state == IDLE) &
                   (mem_valid_rd | mem_valid_wr);
  assign gnt_hit = issue & bus_gnt;
  assign rd_hit  = (issue | (state == WAIT_R)) &
                   ~r_we & bus_rvalid;
  assign last_i  = r_unit ? (icnt == LAST) : 1'b1;
  assign last_r  = r_unit ? (rcnt == LAST) : 1'b1;

  assign mem_ready   = (state == IDLE) & ~rst;
  assign mem_valid_o = (state == RESP);

  // Beat drive; idle bus lines sit at zero.
  always_comb begin
    bus_req   = issue;
    bus_we    = issue & r_we;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (issue) begin
      bus_addr = r_base + AW'({icnt, 2'b00});
      bus_be   = (r_we & ~r_unit) ? al_be : 4'hF;
      if (r_we)
        bus_wdata = r_unit ?
          r_wdata[BUS_DW*icnt +: BUS_DW] : al_wdata;
    end
  end

  // Line buffer with the incoming word dropped into its slot.
  always_comb begin
    nbuf = rbuf;
    nbuf[BUS_DW*rcnt +: BUS_DW] = bus_rdata;
  end

  // Next-state: writes retire on last grant, reads on last rvalid.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept) state_nx = ISSUE;
      ISSUE:
        if (gnt_hit & last_i) begin
          if (r_we)                 state_nx = IDLE;
          else if (rd_hit & last_r) state_nx = RESP;
          else                      state_nx = WAIT_R;
        end
      WAIT_R:
        if (rd_hit & last_r) state_nx = RESP;
      RESP:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // State, request latch, beat counters and read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      icnt       <= '0;
      rcnt       <= '0;
      r_we       <= 1'b0;
      r_unit     <= 1'b0;
      r_sew      <= '0;
      r_off      <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      rbuf       <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we    <= ~mem_valid_rd;
        r_unit  <= mem_unit;
        r_sew   <= mem_sew;
        r_off   <= mem_address[1:0];
        r_base  <= {mem_address[AW-1:2], 2'b00};
        r_wdata <= mem_data_wr;
        icnt    <= '0;
        rcnt    <= '0;
      end
      if (gnt_hit)
        icnt <= icnt + 1'b1;
      if (rd_hit) begin
        rcnt <= rcnt + 1'b1;
        rbuf <= nbuf;
        if (last_r)
          mem_data_o <= r_unit ? nbuf : LDW'(al_rlane);
      end
    end
  end

  // Read wins over a simultaneous write; the write is dropped.
  cover property (@(posedge clk)
    !rst && state == IDLE && mem_valid_rd && mem_valid_wr);

endmodule

// File: tb/tb_vector_mem_bridge.sv
// Scoreboard bench for vector_mem_bridge with a word-bus model.
// Expected beats and read lines are queued when a request is driven.
module tb_vector_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_valid_rd, mem_valid_wr, mem_unit;
  logic [1:0]   mem_sew;
  logic [31:0]  mem_address;
  logic [255:0] mem_data_wr;
  logic         mem_ready, mem_valid_o;
  logic [255:0] mem_data_o;
  logic         bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0]  bus_addr, bus_wdata, bus_rdata;
  logic [3:0]   bus_be;

  logic         rv_q = 1'b0;
  logic [31:0]  rd_q = '0;
  logic         tgl = 1'b0;
  logic         gnt_alt = 1'b0;
  logic         stray = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t        exp_beats[$];
  logic [255:0] exp_data[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_mem_bridge dut (
    .clk(clk), .rst(rst),
    .mem_valid_rd(mem_valid_rd), .mem_valid_wr(mem_valid_wr),
    .mem_unit(mem_unit), .mem_sew(mem_sew),
    .mem_address(mem_address), .mem_data_wr(mem_data_wr),
    .mem_ready(mem_ready), .mem_valid_o(mem_valid_o),
    .mem_data_o(mem_data_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h400) return 32'hAABB_CCDD;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Word bus: read data returns exactly one cycle after grant.
  always @(posedge clk) begin
    tgl <= ~tgl;
    if (rst) rv_q <= 1'b0;
    else begin
      rv_q <= bus_req && bus_gnt && !bus_we;
      rd_q <= mem_word(bus_addr);
    end
  end

  assign bus_gnt    = gnt_alt ? tgl : 1'b1;
  assign bus_rvalid = rv_q | stray;
  assign bus_rdata  = stray ? 32'hDEAD_BEEF : rd_q;

  task automatic push_beat(input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] be);
    beat_t b;
    b.addr = a; b.we = we; b.wdata = wd; b.be = be;
    exp_beats.push_back(b);
  endtask

  // Drive one request for cycle 0, then scramble the inputs.
  task automatic start(input logic rd, input logic wr, input logic unit,
                       input logic [1:0] sew, input logic [31:0] addr,
                       input logic [255:0] data);
    mem_valid_rd = rd; mem_valid_wr = wr; mem_unit = unit;
    mem_sew = sew; mem_address = addr; mem_data_wr = data;
    @(negedge clk);
    mem_valid_rd = 0; mem_valid_wr = 0;
    mem_unit = ~unit; mem_sew = ~sew;
    mem_address = $urandom; mem_data_wr = {8{$urandom}};
  endtask

  // Scoreboard monitor from cycle 1 until the bridge is idle again.
  task automatic run_txn(input int max, output int vcyc, output int rcyc);
    int cyc;
    bit done;
    beat_t e;
    logic [255:0] d;
    cyc = 1; done = 0; vcyc = -1; rcyc = -1;
    while (!done && cyc <= max) begin
      if (bus_req && bus_gnt) begin
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $display("FAIL extra_beat addr=%h we=%b", bus_addr, bus_we);
        end else begin
          e = exp_beats.pop_front();
          if ({bus_addr, bus_we} !== {e.addr, e.we} ||
              (e.we && {bus_wdata, bus_be} !== {e.wdata, e.be})) begin
            errors++;
            $display("FAIL beat got addr=%h we=%b wd=%h be=%h want addr=%h we=%b wd=%h be=%h",
                     bus_addr, bus_we, bus_wdata, bus_be,
                     e.addr, e.we, e.wdata, e.be);
          end
        end
      end
      if (mem_valid_o) begin
        vcyc = cyc;
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL extra_valid data=%h", mem_data_o);
        end else begin
          d = exp_data.pop_front();
          if (mem_data_o !== d) begin
            errors++;
            $display("FAIL read_data got=%h want=%h", mem_data_o, d);
          end
        end
      end
      if (mem_ready && cyc > 1) begin
        rcyc = cyc; done = 1;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout got=busy want=idle within %0d", max);
    end
    checks++;
    if (exp_beats.size() != 0) begin
      errors++;
      $display("FAIL missing_beats got=%0d left want=0", exp_beats.size());
    end
    checks++;
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL missing_valid got=%0d left want=0", exp_data.size());
    end
    exp_beats.delete(); exp_data.delete();
  endtask

  task automatic chk_ready;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req got=%b want=1", mem_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_ready, mem_valid_o, bus_req, bus_we} !== 4'b0 ||
        {bus_addr, bus_wdata, bus_be} !== 68'b0 ||
        mem_data_o !== 256'b0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b v=%b req=%b we=%b a=%h wd=%h be=%h d=%h want zeros",
               mem_ready, mem_valid_o, bus_req, bus_we,
               bus_addr, bus_wdata, bus_be, mem_data_o);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b want=1", mem_ready);
    end
  endtask

  task automatic test_unit_read;
    int v, r;
    logic [255:0] d;
    chk_ready();
    for (int k = 0; k < 8; k++) begin
      push_beat(32'h100 + 4*k, 1'b0, 32'h0, 4'h0);
      d[32*k +: 32] = 32'h1000_0040 + k;
    end
    exp_data.push_back(d);
    start(1, 0, 1, 2'b10, 32'h100, '0);
    run_txn(40, v, r);
    checks++;
    if (v != 10 || r != 11) begin
      errors++;
      $display("FAIL unit_read_lat got v=%0d r=%0d want v=10 r=11", v, r);
    end
    checks++;
    if (mem_data_o[255:224] !== 32'h1000_0047) begin
      errors++;
      $display("FAIL unit_read_top got=%h want=10000047", mem_data_o[255:224]);
    end
  endtask

  task automatic test_unit_write;
    int v, r;
    logic [255:0] d, held;
    held = mem_data_o;
    gnt_alt = 1;
    chk_ready();
    for (int k = 0; k < 8; k++) begin
      d[32*k +: 32] = 32'hC0DE_0000 + 32'h111 * k;
      push_beat(32'h200 + 4*k, 1'b1, 32'hC0DE_0000 + 32'h111 * k, 4'hF);
    end
    start(0, 1, 1, 2'b00, 32'h200, d);
    run_txn(60, v, r);
    gnt_alt = 0;
    checks++;
    if (v != -1 || r < 16) begin
      errors++;
      $display("FAIL unit_write_lat got v=%0d r=%0d want v=-1 r>=16", v, r);
    end
    checks++;
    if (mem_data_o !== held) begin
      errors++;
      $display("FAIL write_holds_rdata got=%h want=%h", mem_data_o, held);
    end
  endtask

  task automatic test_elem_write;
    int v, r;
    chk_ready();
    push_beat(32'h300, 1'b1, 32'hBEEF_0000, 4'b1100);
    start(0, 1, 0, 2'b01, 32'h302, 256'hBEEF);
    run_txn(20, v, r);
    checks++;
    if (r != 2) begin
      errors++;
      $display("FAIL elem_write_lat got r=%0d want 2", r);
    end
    chk_ready();
    push_beat(32'h308, 1'b1, 32'h4400_0000, 4'b1000);
    start(0, 1, 0, 2'b10, 32'h30B, 256'h1122_3344);
    run_txn(20, v, r);
    checks++;
    if (r != 2) begin
      errors++;
      $display("FAIL b2b_write_lat got r=%0d want 2", r);
    end
  endtask

  task automatic test_elem_read;
    int v, r;
    chk_ready();
    push_beat(32'h400, 1'b0, 32'h0, 4'h0);
    exp_data.push_back(256'hCC);
    start(1, 0, 0, 2'b00, 32'h401, '0);
    run_txn(20, v, r);
    checks++;
    if (v != 3 || r != 4) begin
      errors++;
      $display("FAIL elem_read_lat got v=%0d r=%0d want v=3 r=4", v, r);
    end
  endtask

  task automatic test_collision;
    int v, r;
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    checks++;
    if (mem_data_o !== 256'hCC) begin
      errors++;
      $display("FAIL stray_rvalid got=%h want=cc", mem_data_o);
    end
    chk_ready();
    push_beat(32'h500, 1'b0, 32'h0, 4'h0);
    exp_data.push_back(256'h1000_0140);
    start(1, 1, 0, 2'b10, 32'h500, 256'h1234_5678);
    run_txn(20, v, r);
    checks++;
    if (v != 3) begin
      errors++;
      $display("FAIL collision_lat got v=%0d want 3", v);
    end
  endtask

  task automatic test_mid_reset;
    int v, r;
    bit bad;
    chk_ready();
    start(1, 0, 1, 2'b10, 32'h100, '0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_reset got req=%b rdy=%b want 0 0", bus_req, mem_ready);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || mem_ready !== 1'b1 || mem_data_o !== '0) begin
      errors++;
      $display("FAIL after_reset got req=%b rdy=%b d=%h want 0 1 0",
               bus_req, mem_ready, mem_data_o);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid_o || bus_req) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ghost_activity got=1 want=0");
    end
    chk_ready();
    push_beat(32'h404, 1'b0, 32'h0, 4'h0);
    exp_data.push_back(256'h1000_0101);
    start(1, 0, 0, 2'b10, 32'h404, '0);
    run_txn(20, v, r);
    checks++;
    if (v != 3) begin
      errors++;
      $display("FAIL post_reset_read got v=%0d want 3", v);
    end
  endtask

  initial begin
    rst = 1; mem_valid_rd = 0; mem_valid_wr = 0; mem_unit = 0;
    mem_sew = 0; mem_address = 0; mem_data_wr = 0;
    @(negedge clk);
    test_reset();
    test_unit_read();
    test_unit_write();
    test_elem_write();
    test_elem_read();
    test_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
